// File: rtl/tune_sequencer_pkg.sv
// Shared types for the tune sequencer: FSM state encoding and note layout.
package tune_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    CALC  = 2'd2,
    PLAY  = 2'd3
  } statetype;

  // Default-width note record. Packages cannot be parameterised, so the top
  // declares an equivalent struct at its own DATA_W.
  localparam int NOTE_DATA_W = 8;

  typedef struct packed {
    logic [NOTE_DATA_W-1:0] pitch;
    logic [NOTE_DATA_W-1:0] dur;
  } note_t;

  // Width of a note index; a single-note frame still gets a 1-bit index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tune_sequencer_if.sv
// Control/status bundle between the frame decode path and the sequencer.
//
// Handshake: frame_valid is a one-cycle strobe with no back-pressure. On the
// clock edge where it is high, frame_data and rep_count are captured and
// playback (re)starts. stop is level-sampled each cycle; when both are high,
// frame_valid takes priority. All status signals are registered in the DUT.
interface tune_sequencer_if #(
  parameter int NUM_NOTES = 3,
  parameter int DATA_W    = 8,
  parameter int REP_W     = 2
);
  import tune_pkg::*;

  localparam int IDX_W = idx_width(NUM_NOTES);

  logic                          frame_valid;
  logic [NUM_NOTES*2*DATA_W-1:0] frame_data;
  logic [REP_W-1:0]              rep_count;
  logic                          stop;
  logic                          pwm;
  logic                          busy;
  logic [IDX_W-1:0]              note_idx;
  logic                          seq_done;
  statetype                      state;     // FSM state, for debug/observation

  modport master (
    output frame_valid, frame_data, rep_count, stop,
    input  pwm, busy, note_idx, seq_done, state
  );

  modport slave (
    input  frame_valid, frame_data, rep_count, stop,
    output pwm, busy, note_idx, seq_done, state
  );

endinterface

// File: rtl/tune_sequencer_seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle.
// done pulses W+1 cycles after start. A zero divisor makes every trial
// subtraction succeed, so the quotient naturally comes out all-ones.
module seq_divider #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start_i,
  input  logic         abort_i,
  input  logic [W-1:0] dividend_i,
  input  logic [W-1:0] divisor_i,
  output logic [W-1:0] quotient_o,
  output logic         done_o
);

  localparam int CNT_W = $clog2(W + 1);

  logic [W-1:0]     rem_q, rem_d;
  logic [W-1:0]     quo_q, quo_d;
  logic [W-1:0]     dsor_q, dsor_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             active_q, active_d;
  logic             done_q, done_d;
  logic [W:0]       rem_sh;
  logic [W:0]       diff;

  // One shift/trial-subtract step per cycle while active.
  always_comb begin
    rem_d    = rem_q;
    quo_d    = quo_q;
    dsor_d   = dsor_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    done_d   = 1'b0;
    rem_sh   = {rem_q, quo_q[W-1]};
    diff     = rem_sh - {1'b0, dsor_q};
    if (abort_i) begin
      active_d = 1'b0;
    end else if (start_i) begin
      rem_d    = '0;
      quo_d    = dividend_i;
      dsor_d   = divisor_i;
      cnt_d    = CNT_W'(W);
      active_d = 1'b1;
    end else if (active_q) begin
      if (!diff[W]) begin
        rem_d = diff[W-1:0];
        quo_d = {quo_q[W-2:0], 1'b1};
      end else begin
        rem_d = rem_sh[W-1:0];
        quo_d = {quo_q[W-2:0], 1'b0};
      end
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        active_d = 1'b0;
        done_d   = 1'b1;
      end
    end
  end

  // Divider state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rem_q    <= '0;
      quo_q    <= '0;
      dsor_q   <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dsor_q   <= dsor_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
      done_q   <= done_d;
    end
  end

  assign quotient_o = quo_q;
  assign done_o     = done_q;

endmodule

// File: rtl/tune_sequencer.sv
// Plays a captured frame of (pitch, duration) notes as a square wave on pwm,
// repeating the whole frame rep_count+1 times.
module tune_sequencer
  import tune_pkg::*;
#(
  parameter int NUM_NOTES  = 3,
  parameter int DATA_W     = 8,
  parameter int REP_W      = 2,
  parameter int CLK_HZ     = 24000000,
  parameter int FREQ_SCALE = 3,
  parameter int DUR_UNIT   = 240000,
  parameter int DIV_W      = 24
) (
  input logic             clk,
  input logic             reset_n,
  tune_sequencer_if.slave bus
);

  localparam int NOTE_W  = 2 * DATA_W;
  localparam int FRAME_W = NUM_NOTES * NOTE_W;
  localparam int IDX_W   = idx_width(NUM_NOTES);
  localparam int DSOR_W  = DATA_W + $clog2(FREQ_SCALE + 1);
  localparam int DUR_W   = DATA_W + $clog2(DUR_UNIT + 1);

  localparam logic [DIV_W-1:0] HALF_CLK   = DIV_W'(CLK_HZ / 2);
  localparam logic [DUR_W-1:0] DUR_UNIT_C = DUR_W'(DUR_UNIT);

  typedef struct packed {
    logic [DATA_W-1:0] pitch;
    logic [DATA_W-1:0] dur;
  } note_w_t;

  statetype           state_q, state_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [REP_W-1:0]   rep_q, rep_d;
  logic [REP_W-1:0]   pass_q, pass_d;
  logic [IDX_W-1:0]   note_idx_q, note_idx_d;
  logic [DIV_W-1:0]   half_q, half_d;
  logic [DIV_W-1:0]   hcnt_q, hcnt_d;
  logic [DUR_W-1:0]   dcnt_q, dcnt_d;
  logic               pwm_q, pwm_d;
  logic               done_q, done_d;

  note_w_t            cur_note;
  logic [DSOR_W-1:0]  dsor_note;
  logic [DIV_W-1:0]   div_divisor;
  logic [DIV_W-1:0]   div_q;
  logic [DIV_W-1:0]   half_from_div;
  logic [DUR_W-1:0]   play_len;
  logic               div_start;
  logic               div_abort;
  logic               div_done;

  // Select the current note; note 0 lives in the frame MSBs.
  always_comb begin
    cur_note = '0;
    for (int i = 0; i < NUM_NOTES; i++) begin
      if (note_idx_q == IDX_W'(i)) begin
        cur_note = frame_q[(NUM_NOTES-1-i)*NOTE_W +: NOTE_W];
      end
    end
  end

  // Per-note derived values: divisor, clamped half-period, note length.
  always_comb begin
    dsor_note     = DSOR_W'(cur_note.pitch) * DSOR_W'(FREQ_SCALE);
    div_divisor   = DIV_W'(dsor_note);
    half_from_div = (div_q == '0) ? DIV_W'(1) : div_q;
    play_len      = DUR_W'(cur_note.dur) * DUR_UNIT_C;
  end

  seq_divider #(.W(DIV_W)) u_div (
    .clk        (clk),
    .reset_n    (reset_n),
    .start_i    (div_start),
    .abort_i    (div_abort),
    .dividend_i (HALF_CLK),
    .divisor_i  (div_divisor),
    .quotient_o (div_q),
    .done_o     (div_done)
  );

  // Next-state and datapath control; restart and stop override every state.
  always_comb begin
    state_d    = state_q;
    frame_d    = frame_q;
    rep_d      = rep_q;
    pass_d     = pass_q;
    note_idx_d = note_idx_q;
    half_d     = half_q;
    hcnt_d     = hcnt_q;
    dcnt_d     = dcnt_q;
    pwm_d      = pwm_q;
    done_d     = 1'b0;
    div_start  = 1'b0;
    div_abort  = 1'b0;
    if (bus.frame_valid) begin
      frame_d    = bus.frame_data;
      rep_d      = bus.rep_count;
      pass_d     = '0;
      note_idx_d = '0;
      pwm_d      = 1'b0;
      div_abort  = 1'b1;
      state_d    = SETUP;
    end else if (bus.stop) begin
      pwm_d     = 1'b0;
      div_abort = 1'b1;
      state_d   = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        SETUP: begin
          if (cur_note.pitch == '0) begin
            // Rest: no division, pwm held low for the note length.
            half_d  = '0;
            hcnt_d  = '0;
            dcnt_d  = play_len;
            pwm_d   = 1'b0;
            state_d = PLAY;
          end else begin
            div_start = 1'b1;
            state_d   = CALC;
          end
        end
        CALC: begin
          if (div_done) begin
            half_d  = half_from_div;
            hcnt_d  = '0;
            dcnt_d  = play_len;
            pwm_d   = 1'b0;
            state_d = PLAY;
          end
        end
        PLAY: begin
          if (half_q != '0) begin
            if (hcnt_q == half_q - DIV_W'(1)) begin
              pwm_d  = ~pwm_q;
              hcnt_d = '0;
            end else begin
              hcnt_d = hcnt_q + DIV_W'(1);
            end
          end
          dcnt_d = (dcnt_q == '0) ? '0 : dcnt_q - DUR_W'(1);
          // Last cycle of the note (a zero-length note still gets one cycle).
          if (dcnt_q <= DUR_W'(1)) begin
            pwm_d  = 1'b0;
            hcnt_d = '0;
            if (note_idx_q < IDX_W'(NUM_NOTES - 1)) begin
              note_idx_d = note_idx_q + IDX_W'(1);
              state_d    = SETUP;
            end else if (pass_q < rep_q) begin
              pass_d     = pass_q + REP_W'(1);
              note_idx_d = '0;
              state_d    = SETUP;
            end else begin
              done_d  = 1'b1;
              state_d = IDLE;
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      frame_q    <= '0;
      rep_q      <= '0;
      pass_q     <= '0;
      note_idx_q <= '0;
      half_q     <= '0;
      hcnt_q     <= '0;
      dcnt_q     <= '0;
      pwm_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      frame_q    <= frame_d;
      rep_q      <= rep_d;
      pass_q     <= pass_d;
      note_idx_q <= note_idx_d;
      half_q     <= half_d;
      hcnt_q     <= hcnt_d;
      dcnt_q     <= dcnt_d;
      pwm_q      <= pwm_d;
      done_q     <= done_d;
    end
  end

  assign bus.pwm      = pwm_q;
  assign bus.busy     = (state_q != IDLE);
  assign bus.note_idx = note_idx_q;
  assign bus.seq_done = done_q;
  assign bus.state    = state_q;

endmodule

// File: tb/tb_tune_sequencer.sv
// Directed bench for tune_sequencer with a per-note expected queue.
module tb_tune_sequencer;
  import tune_pkg::*;

  localparam int TB_NOTES  = 3;
  localparam int TB_DATA_W = 8;
  localparam int TB_CLK_HZ = 1200;
  localparam int TB_FSCALE = 1;
  localparam int TB_DUNIT  = 100;
  localparam int TB_DIV_W  = 12;
  localparam int CALC_LEN  = TB_DIV_W + 1;
  localparam int MAX_CYC   = 5000;

  logic clk;
  logic reset_n;
  int   checks;
  int   failures;

  // Per-note expectation: {idx[3:0], half_period[11:0], play_cycles[15:0]}.
  logic [31:0] exp_q[$];

  tune_sequencer_if #(.NUM_NOTES(TB_NOTES), .DATA_W(TB_DATA_W), .REP_W(2)) sif ();

  tune_sequencer #(
    .NUM_NOTES  (TB_NOTES),
    .DATA_W     (TB_DATA_W),
    .REP_W      (2),
    .CLK_HZ     (TB_CLK_HZ),
    .FREQ_SCALE (TB_FSCALE),
    .DUR_UNIT   (TB_DUNIT),
    .DIV_W      (TB_DIV_W)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (sif)
  );

  // Clock / reset block.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [47:0] mk(input int p0, input int d0, input int p1,
                                     input int d1, input int p2, input int d2);
    note_t n0, n1, n2;
    n0.pitch = 8'(p0); n0.dur = 8'(d0);
    n1.pitch = 8'(p1); n1.dur = 8'(d1);
    n2.pitch = 8'(p2); n2.dur = 8'(d2);
    return {n0, n1, n2};
  endfunction

  // Expected notes for a whole frame and all its repeats.
  task automatic push_frame(input logic [47:0] f, input int rep);
    for (int p = 0; p <= rep; p++) begin
      for (int n = 0; n < TB_NOTES; n++) begin
        logic [15:0] nt;
        int pitch, dur, half, len;
        nt    = f[(TB_NOTES-1-n)*16 +: 16];
        pitch = int'(nt[15:8]);
        dur   = int'(nt[7:0]);
        half  = (pitch == 0) ? 0 : (TB_CLK_HZ / 2) / (TB_FSCALE * pitch);
        if (pitch != 0 && half == 0) half = 1;
        len   = (dur == 0) ? 1 : dur * TB_DUNIT;
        exp_q.push_back({4'(n), 12'(half), 16'(len)});
      end
    end
  endtask

  // Driver: one-cycle frame strobe, optionally together with stop.
  task automatic send_frame(input logic [47:0] f, input logic [1:0] rep, input logic with_stop);
    @(negedge clk);
    sif.frame_valid = 1'b1;
    sif.frame_data  = f;
    sif.rep_count   = rep;
    sif.stop        = with_stop;
    @(negedge clk);
    sif.frame_valid = 1'b0;
    sif.stop        = 1'b0;
    sif.frame_data  = 48'({$urandom(), $urandom()});
    sif.rep_count   = 2'($urandom_range(0, 3));
    check("start_state", 32'(sif.state), 32'(SETUP));
    check("start_busy", 32'(sif.busy), 32'd1);
    check("start_idx", 32'(sif.note_idx), 32'd0);
    check("start_done", 32'(sif.seq_done), 32'd0);
  endtask

  // Monitor until IDLE: pops one expectation per PLAY segment.
  task automatic run_seq(input string tag, input int exp_done, input int exp_calc_seen);
    logic [31:0] e;
    int k, pwm_err, done_cnt, calc_len, calc_bad, calc_seen, exp_pwm, half;
    logic in_play, finished;
    k = 0; pwm_err = 0; done_cnt = 0; calc_len = 0; calc_bad = 0; calc_seen = 0;
    in_play = 1'b0; finished = 1'b0; e = '1; half = 0;
    for (int cyc = 0; cyc < MAX_CYC; cyc++) begin
      @(negedge clk);
      if (sif.state == PLAY) begin
        if (!in_play) begin
          in_play = 1'b1;
          k = 0;
          e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
          half = int'(e[27:16]);
          check({tag, "_note_idx"}, 32'(sif.note_idx), 32'(e[31:28]));
        end
        exp_pwm = (half == 0) ? 0 : ((k / half) % 2);
        if (sif.pwm !== 1'(exp_pwm)) pwm_err++;
        k++;
      end else begin
        if (in_play) begin
          check({tag, "_note_len"}, 32'(k), 32'(e[15:0]));
          in_play = 1'b0;
        end
        if (sif.pwm !== 1'b0) pwm_err++;
        if (sif.state == CALC) begin
          calc_len++;
        end else if (calc_len != 0) begin
          calc_seen++;
          if (calc_len != CALC_LEN) calc_bad++;
          calc_len = 0;
        end
      end
      if (sif.seq_done === 1'b1) begin
        done_cnt++;
        check({tag, "_busy_at_done"}, 32'(sif.busy), 32'd0);
      end
      if (sif.state == IDLE) begin
        finished = 1'b1;
        break;
      end
    end
    check({tag, "_finished"}, 32'(finished), 32'd1);
    check({tag, "_pwm_errors"}, 32'(pwm_err), 32'd0);
    check({tag, "_calc_len_errors"}, 32'(calc_bad), 32'd0);
    if (exp_calc_seen >= 0) check({tag, "_calc_entries"}, 32'(calc_seen), 32'(exp_calc_seen));
    check({tag, "_seq_done_count"}, 32'(done_cnt), 32'(exp_done));
    check({tag, "_queue_left"}, 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    check({tag, "_done_one_cycle"}, 32'(sif.seq_done), 32'd0);
  endtask

  initial begin
    logic [47:0] f;
    int n, done_seen;
    checks = 0;
    failures = 0;
    reset_n = 1'b0;
    sif.frame_valid = 1'b0;
    sif.frame_data  = '0;
    sif.rep_count   = '0;
    sif.stop        = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Reset state.
    check("rst_state", 32'(sif.state), 32'(IDLE));
    check("rst_pwm", 32'(sif.pwm), 32'd0);
    check("rst_busy", 32'(sif.busy), 32'd0);
    check("rst_idx", 32'(sif.note_idx), 32'd0);
    check("rst_done", 32'(sif.seq_done), 32'd0);

    // Single note then two zero-length rests.
    f = mk(10, 2, 0, 0, 0, 0);
    push_frame(f, 0);
    send_frame(f, 2'd0, 1'b0);
    run_seq("single", 1, 1);

    // Three notes repeated three times.
    f = mk(20, 1, 30, 1, 40, 1);
    push_frame(f, 2);
    send_frame(f, 2'd2, 1'b0);
    run_seq("repeat", 1, 9);

    // Rests only: divider never used.
    f = mk(0, 3, 0, 0, 0, 2);
    push_frame(f, 0);
    send_frame(f, 2'd0, 1'b0);
    run_seq("rest", 1, 0);

    // Restart in the middle of note 1.
    f = mk(20, 1, 30, 1, 40, 1);
    send_frame(f, 2'd1, 1'b0);
    n = 0;
    done_seen = 0;
    while (!(sif.state == PLAY && sif.note_idx == 2'd1) && n < MAX_CYC) begin
      @(negedge clk);
      if (sif.seq_done === 1'b1) done_seen++;
      n++;
    end
    check("restart_reach_state", 32'(sif.state), 32'(PLAY));
    check("restart_reach_idx", 32'(sif.note_idx), 32'd1);
    repeat ($urandom_range(5, 40)) begin
      @(negedge clk);
      if (sif.seq_done === 1'b1) done_seen++;
    end
    check("restart_no_done_before", 32'(done_seen), 32'd0);
    f = mk(50, 1, 0, 0, 0, 0);
    send_frame(f, 2'd0, 1'b0);
    push_frame(f, 0);
    run_seq("restart", 1, -1);

    // frame_valid and stop together: the new frame wins.
    f = mk(0, 1, 0, 0, 0, 0);
    push_frame(f, 0);
    send_frame(mk(25, 2, 0, 0, 0, 0), 2'd0, 1'b0);
    repeat ($urandom_range(20, 60)) @(negedge clk);
    send_frame(f, 2'd0, 1'b1);
    run_seq("fv_over_stop", 1, 0);

    // Stop during CALC.
    send_frame(mk(100, 5, 0, 0, 0, 0), 2'd0, 1'b0);
    repeat ($urandom_range(1, 10)) @(negedge clk);
    check("stop_in_calc", 32'(sif.state), 32'(CALC));
    sif.stop = 1'b1;
    @(negedge clk);
    sif.stop = 1'b0;
    check("stop_state", 32'(sif.state), 32'(IDLE));
    check("stop_pwm", 32'(sif.pwm), 32'd0);
    check("stop_busy", 32'(sif.busy), 32'd0);
    done_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (sif.seq_done === 1'b1 || sif.state != IDLE) done_seen++;
    end
    check("stop_stays_idle", 32'(done_seen), 32'd0);

    // Asynchronous reset in the middle of note 1 while pwm is high.
    send_frame(mk(0, 0, 10, 2, 0, 0), 2'd0, 1'b0);
    n = 0;
    while (!(sif.state == PLAY && sif.note_idx == 2'd1 && sif.pwm == 1'b1) && n < MAX_CYC) begin
      @(negedge clk);
      n++;
    end
    check("rstplay_reach_pwm", 32'(sif.pwm), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    check("rstplay_pwm", 32'(sif.pwm), 32'd0);
    check("rstplay_busy", 32'(sif.busy), 32'd0);
    check("rstplay_idx", 32'(sif.note_idx), 32'd0);
    check("rstplay_done", 32'(sif.seq_done), 32'd0);
    check("rstplay_state", 32'(sif.state), 32'(IDLE));
    @(negedge clk);
    reset_n = 1'b1;

    // Recovery after reset.
    f = mk(30, 1, 0, 0, 0, 0);
    push_frame(f, 0);
    send_frame(f, 2'd0, 1'b0);
    run_seq("post_reset", 1, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tune_sequencer.md
Name: tune_sequencer

Overview:
Parametrised successor to the three-note tune FSM. Plays a frame of NUM_NOTES (pitch, duration) pairs as a square wave on pwm, and repeats the whole sequence a programmable number of times. It sits between the SPI frame capture/decode path and the pwm pin. Half-periods come from an exact sequential division, not from constant arithmetic.

Parameters:
NUM_NOTES, 3, notes per frame (>=1)
DATA_W, 8, width of each pitch code and duration code
REP_W, 2, width of rep_count
CLK_HZ, 24000000, clk frequency in Hz
FREQ_SCALE, 3, Hz per pitch code step: f = FREQ_SCALE*pitch
DUR_UNIT, 240000, clk cycles per duration code step (10 ms at default)
DIV_W, 24, width of dividend, quotient and half-period counter; must hold CLK_HZ/2

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
frame_valid  in  1  1-cycle strobe; captures frame_data and rep_count, starts playback
frame_data  in  NUM_NOTES*2*DATA_W  note 0 in MSBs; each note is {pitch[DATA_W], dur[DATA_W]}
rep_count  in  REP_W  sequence plays rep_count+1 times
stop  in  1  abort playback, return to IDLE
pwm  out  1  tone output
busy  out  1  high in every state except IDLE
note_idx  out  max(1,$clog2(NUM_NOTES))  index of the current note
seq_done  out  1  1-cycle pulse on natural completion of all repeats

Behaviour:
- Reset (async, reset_n=0): state IDLE; pwm=0, busy=0, note_idx=0, seq_done=0; all counters 0; frame register 0.
- States: IDLE, SETUP, CALC, PLAY.
- IDLE: on frame_valid, register frame and rep_count, set note_idx=0 and pass counter=0, go to SETUP. busy rises the cycle after the frame_valid edge.
- SETUP, 1 cycle:
  - pitch==0 (rest): half_period=0, go to PLAY.
  - Otherwise start the divider: dividend CLK_HZ/2, divisor FREQ_SCALE*pitch, width DATA_W+$clog2(FREQ_SCALE+1). Go to CALC.
- CALC: wait for div_done (DIV_W+1 cycles after start). Latch half_period = max(quotient,1). Go to PLAY.
- PLAY, on entry:
  - pwm=0; half-period counter=0; duration counter loaded with dur*DUR_UNIT (width DATA_W+$clog2(DUR_UNIT+1)).
  - pwm toggles when the half-period counter reaches half_period-1, then the counter clears. A rest holds pwm=0.
  - dur==0: exactly 1 PLAY cycle, then advance.
  - Otherwise the note lasts dur*DUR_UNIT cycles, then advances.
- Advance:
  - If note_idx<NUM_NOTES-1: note_idx+1, go to SETUP.
  - Else if pass<rep_count: pass+1, note_idx=0, go to SETUP.
  - Else: seq_done=1 for 1 cycle, pwm=0, go to IDLE.
- frame_valid in any non-IDLE state: abort the current note and divider, reload the frame, restart from note 0 pass 0 in SETUP next cycle. No seq_done.
- stop: go to IDLE next cycle with pwm=0 and no seq_done. If stop and frame_valid coincide, frame_valid wins.
- pwm is registered; no combinational path from inputs to outputs.
- Frame capture is the only sampling point; frame_data changes between strobes are ignored.

Decomposition:
- Package tune_pkg: statetype enum {IDLE, SETUP, CALC, PLAY} (logic[1:0]) and a note_t struct {pitch, dur}.
- Sub-module seq_divider, parametrised by width:
  - Restoring unsigned divider: start, dividend, divisor in; quotient, done out; 1 bit per cycle.
  - Divide-by-zero returns all-ones. It is unreachable from this block, since pitch 0 is handled as a rest.

Test Plan:
1. Bench overrides for all scenarios: CLK_HZ=1200, FREQ_SCALE=1, DUR_UNIT=100, NUM_NOTES=3, DIV_W=12.
2. Single note: frame {10,2 | 0,0 | 0,0}, rep 0 -> half_period 60; pwm toggles every 60 cycles for 200 PLAY cycles. Note 2 dur 0 lasts 1 cycle. seq_done pulses once; busy falls the same cycle.
3. Repeat: frame {20,1 | 30,1 | 40,1}, rep 2 -> note_idx sequence 0,1,2 appears 3 times; half_periods 30,20,15. seq_done only after the 9th note.
4. Rest: pitch 0, dur 3 -> pwm stays 0 for 300 cycles; no divider start (CALC never entered).
5. Restart: second frame_valid mid-note 1 -> next cycle is SETUP with note_idx=0 and the new frame data; no seq_done.
6. Abort and reset: stop during CALC -> IDLE next cycle, pwm=0, busy=0. Also reset_n low mid-PLAY -> all outputs 0 immediately, without waiting for a clk edge.
